multiexp_kernel_burst_former: RTL

Downstream stage of the pipelined adder. Consumes the adder's output AXI4-Stream and buffers it locally. Chops the stream into write bursts of at most C_MAX_BURST beats and issues one address/length command per burst. The command is issued ahead of that burst's data. Feeds the kernel's AXI4 write master, which forwards cmd_* to AW and m_axis_* to W.

---
 rtl/multiexp_kernel_burst_former.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/multiexp_kernel_burst_former.sv
// rtl/multiexp_kernel_burst_former.sv - buffers the adder output stream and chops it into AXI write bursts
module multiexp_kernel_burst_former #(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_ADDR_WIDTH       = 64,
    parameter int C_MAX_BURST        = 64
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0]         ctrl_addr_offset,
    output logic                            ctrl_done,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                            s_axis_tlast,
    output logic                            cmd_valid,
    input  logic                            cmd_ready,
    output logic [C_ADDR_WIDTH-1:0]         cmd_addr,
    output logic [7:0]                      cmd_len,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                            m_axis_tlast
);

    localparam int LP_BYTES = C_AXIS_TDATA_WIDTH / 8;
    localparam int LP_DEPTH = 2 * C_MAX_BURST;
    localparam int LP_PW    = $clog2(LP_DEPTH);
    localparam int LP_CW    = LP_PW + 1;
    localparam int LP_FW    = C_AXIS_TDATA_WIDTH + LP_BYTES;
    localparam logic [LP_CW-1:0]        LP_MAX_C   = LP_CW'(C_MAX_BURST);
    localparam logic [LP_CW-1:0]        LP_DEPTH_C = LP_CW'(LP_DEPTH);
    localparam logic [C_ADDR_WIDTH-1:0] LP_BYTES_A = C_ADDR_WIDTH'(LP_BYTES);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_CMD, S_DATA, S_DONE} state_t;

    state_t                  state, state_nxt;
    logic [LP_FW-1:0]        mem [LP_DEPTH];
    logic [LP_PW-1:0]        wr_ptr, rd_ptr;
    logic [LP_CW-1:0]        fifo_count, count_nxt, beats_to_last;
    logic                    tlast_seen, tlast_nxt;
    logic [8:0]              burst_beats;
    logic [7:0]              beat_cnt;
    logic                    burst_final;
    logic [C_ADDR_WIDTH-1:0] addr_r;
    logic                    wr_en, rd_en, last_hs, fill_go, fifo_empty, tready_nxt;

    assign wr_en      = s_axis_tvalid && s_axis_tready;
    assign rd_en      = m_axis_tvalid && m_axis_tready;
    assign last_hs    = rd_en && m_axis_tlast;
    assign fifo_empty = (fifo_count == '0);
    assign fill_go    = (fifo_count >= LP_MAX_C) || (tlast_seen && beats_to_last != '0);
    assign count_nxt  = fifo_count + LP_CW'(wr_en) - LP_CW'(rd_en);

    assign {m_axis_tkeep, m_axis_tdata} = mem[rd_ptr];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (ctrl_start) state_nxt = S_FILL;
            S_FILL:  if (fill_go) state_nxt = S_CMD;
            S_CMD:   if (cmd_ready) state_nxt = S_DATA;
            S_DATA:  if (last_hs) state_nxt = burst_final ? S_DONE : S_FILL;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl_done     = 1'b0;
        cmd_valid     = 1'b0;
        cmd_addr      = '0;
        cmd_len       = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        case (state)
            S_CMD: begin
                cmd_valid = 1'b1;
                cmd_addr  = addr_r;
                cmd_len   = 8'(burst_beats - 9'd1);
            end
            S_DATA: begin
                m_axis_tvalid = !fifo_empty;
                m_axis_tlast  = !fifo_empty && (beat_cnt == 8'(burst_beats - 9'd1));
            end
            S_DONE:  ctrl_done = 1'b1;
            default: ;
        endcase
    end

    // Input acceptance is decided one cycle ahead so a full FIFO is never written.
    always_comb begin
        tlast_nxt  = (state == S_DONE) ? 1'b0 : (tlast_seen || (wr_en && s_axis_tlast));
        tready_nxt = (state_nxt inside {S_FILL, S_CMD, S_DATA}) &&
                     (count_nxt < LP_DEPTH_C) && !tlast_nxt;
    end

    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr] <= {s_axis_tkeep, s_axis_tdata};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            beats_to_last <= '0;
            tlast_seen    <= 1'b0;
            burst_beats   <= '0;
            beat_cnt      <= '0;
            burst_final   <= 1'b0;
            addr_r        <= '0;
            s_axis_tready <= 1'b0;
        end else begin
            fifo_count    <= count_nxt;
            tlast_seen    <= tlast_nxt;
            s_axis_tready <= tready_nxt;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            // Tracks beats still buffered up to and including the stream's final beat.
            if (wr_en && s_axis_tlast)
                beats_to_last <= fifo_count - LP_CW'(rd_en) + 1'b1;
            else if (rd_en && tlast_seen)
                beats_to_last <= beats_to_last - 1'b1;
            if (state == S_IDLE && ctrl_start) addr_r <= ctrl_addr_offset;
            if (state == S_FILL && fill_go) begin
                burst_final <= tlast_seen && (beats_to_last <= LP_MAX_C);
                burst_beats <= (tlast_seen && beats_to_last <= LP_MAX_C) ?
                               9'(beats_to_last) : 9'(C_MAX_BURST);
                beat_cnt    <= '0;
            end else if (rd_en) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (last_hs) addr_r <= addr_r + C_ADDR_WIDTH'(burst_beats) * LP_BYTES_A;
        end
    end

endmodule
